mips_processor: RTL and testbench

// - Single-cycle 32-bit MIPS subset processor: core "mips" (controller plus datapath "dp"),

---
 rtl/mips_processor.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_mips_processor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_processor.sv
`default_nettype none
// ============================================================================
// mips_processor: single-cycle 32-bit MIPS subset core with instruction ROM
// and word-addressed data RAM.                                     Rev 1.0
// ============================================================================

package mips_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU} alu_op_e;
  typedef enum logic [2:0] {RES_ALU, RES_MEM, RES_HI, RES_LO, RES_PC4, RES_LUI} res_sel_e;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_e;

  typedef struct packed {
    logic     reg_we;
    dst_e     dst;
    alu_op_e  alu_op;
    logic     alu_imm;
    logic     imm_zext;
    res_sel_e res_sel;
    logic     mem_we;
    logic     branch;
    logic     jump;
    logic     jr;
    logic     mult;
  } ctrl_t;
endpackage

module mips_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] registers [32];

  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : registers[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : registers[ra2_i];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) registers[wa_i] <= wd_i;
  end
endmodule

module mips_datapath
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] fields_i,
  input  ctrl_t       ctrl_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic        dmem_we_o
);
  logic [31:0] pc_q, pc_d, hi_q, lo_q;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_y, pc4, wd;
  logic [63:0] prod;
  logic [4:0]  wa;
  logic [15:0] imm;

  assign imm = fields_i[15:0];
  assign pc4 = pc_q + 32'd4;

  mips_regfile gpr (
    .clk   (clk),
    .ra1_i (fields_i[25:21]),
    .ra2_i (fields_i[20:16]),
    .wa_i  (wa),
    .we_i  (ctrl_i.reg_we & ~reset),
    .wd_i  (wd),
    .rd1_o (rs_val),
    .rd2_o (rt_val)
  );

  assign imm_ext = ctrl_i.imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = ctrl_i.alu_imm ? imm_ext : rt_val;
  assign prod    = {32'h0, rs_val} * {32'h0, rt_val};

  always_comb begin
    alu_y = rs_val + alu_b;
    case (ctrl_i.alu_op)
      ALU_SUB:  alu_y = rs_val - alu_b;
      ALU_AND:  alu_y = rs_val & alu_b;
      ALU_OR:   alu_y = rs_val | alu_b;
      ALU_SLT:  alu_y = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'h0, rs_val < alu_b};
      default:  alu_y = rs_val + alu_b;
    endcase
  end

  always_comb begin
    wd = alu_y;
    case (ctrl_i.res_sel)
      RES_MEM: wd = dmem_rdata_i;
      RES_HI:  wd = hi_q;
      RES_LO:  wd = lo_q;
      RES_PC4: wd = pc4;
      RES_LUI: wd = {imm, 16'h0};
      default: wd = alu_y;
    endcase
  end

  always_comb begin
    wa = fields_i[20:16];
    case (ctrl_i.dst)
      DST_RD:  wa = fields_i[15:11];
      DST_RA:  wa = 5'd31;
      default: wa = fields_i[20:16];
    endcase
  end

  always_comb begin
    pc_d = pc4;
    if (ctrl_i.jr)
      pc_d = rs_val;
    else if (ctrl_i.jump)
      pc_d = {pc4[31:28], fields_i, 2'b00};
    else if (ctrl_i.branch && (rs_val == rt_val))
      pc_d = pc4 + {imm_ext[29:0], 2'b00};
  end

  // A reset edge suppresses every architectural write of the instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'h0;
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (ctrl_i.mult) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end
    end
  end

  assign pc_o         = pc_q;
  assign dmem_addr_o  = alu_y;
  assign dmem_wdata_o = rt_val;
  assign dmem_we_o    = ctrl_i.mem_we & ~reset;
endmodule

module mips_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic        dmem_we_o
);
  ctrl_t      ctrl;
  logic [5:0] op, funct;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];

  // Unrecognised op/funct leave ctrl at its all-quiet default, i.e. a nop.
  always_comb begin
    ctrl         = '0;
    ctrl.dst     = DST_RT;
    ctrl.alu_op  = ALU_ADD;
    ctrl.res_sel = RES_ALU;
    case (op)
      6'h00: begin
        ctrl.dst = DST_RD;
        case (funct)
          6'h20, 6'h21: ctrl.reg_we = 1'b1;
          6'h22, 6'h23: begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SUB;  end
          6'h24:        begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_AND;  end
          6'h25:        begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_OR;   end
          6'h2a:        begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLT;  end
          6'h2b:        begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLTU; end
          6'h08:        ctrl.jr = 1'b1;
          6'h19:        ctrl.mult = 1'b1;
          6'h10:        begin ctrl.reg_we = 1'b1; ctrl.res_sel = RES_HI; end
          6'h12:        begin ctrl.reg_we = 1'b1; ctrl.res_sel = RES_LO; end
          default:      ;
        endcase
      end
      6'h08: begin ctrl.reg_we = 1'b1; ctrl.alu_imm = 1'b1; end
      6'h0d: begin
        ctrl.reg_we   = 1'b1;
        ctrl.alu_imm  = 1'b1;
        ctrl.imm_zext = 1'b1;
        ctrl.alu_op   = ALU_OR;
      end
      6'h0f: begin ctrl.reg_we = 1'b1; ctrl.res_sel = RES_LUI; end
      6'h23: begin ctrl.reg_we = 1'b1; ctrl.alu_imm = 1'b1; ctrl.res_sel = RES_MEM; end
      6'h2b: begin ctrl.mem_we = 1'b1; ctrl.alu_imm = 1'b1; end
      6'h04: ctrl.branch = 1'b1;
      6'h02: ctrl.jump = 1'b1;
      6'h03: begin
        ctrl.jump    = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.dst     = DST_RA;
        ctrl.res_sel = RES_PC4;
      end
      default: ;
    endcase
  end

  mips_datapath dp (
    .clk          (clk),
    .reset        (reset),
    .fields_i     (instr_i[25:0]),
    .ctrl_i       (ctrl),
    .dmem_rdata_i (dmem_rdata_i),
    .pc_o         (pc_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_we_o    (dmem_we_o)
  );
endmodule

module mips_imem #(
  parameter int IMEM_WORDS = 64
) (
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0]   INSTRROM [IMEM_WORDS];
  logic [AW-1:0] idx;
  logic          hit;
  logic          unused_bits;

  assign idx         = pc_i[AW+1:2];
  assign hit         = (pc_i[31:AW+2] == '0) && ({1'b0, idx} < (AW+1)'(IMEM_WORDS));
  assign instr_o     = hit ? INSTRROM[idx] : 32'h0;
  assign unused_bits = ^pc_i[1:0];
endmodule

module mips_dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata_o
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   RAM [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic          hit;
  logic          unused_bits;

  // Accesses outside the array read as zero and drop their writes.
  assign idx         = addr_i[AW+1:2];
  assign hit         = (addr_i[31:AW+2] == '0) && ({1'b0, idx} < (AW+1)'(DMEM_WORDS));
  assign rdata_o     = hit ? RAM[idx] : 32'h0;
  assign unused_bits = ^addr_i[1:0];

  always_ff @(posedge clk) begin
    if (we_i && hit) RAM[idx] <= wdata_i;
  end
endmodule

module mips_processor #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic clk,
  input  logic reset
);
  logic [31:0] pc, instr, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;

  mips_core mips (
    .clk          (clk),
    .reset        (reset),
    .instr_i      (instr),
    .dmem_rdata_i (dmem_rdata),
    .pc_o         (pc),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_we_o    (dmem_we)
  );

  mips_imem #(.IMEM_WORDS(IMEM_WORDS)) imem (
    .pc_i    (pc),
    .instr_o (instr)
  );

  mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
    .clk     (clk),
    .addr_i  (dmem_addr),
    .wdata_i (dmem_wdata),
    .we_i    (dmem_we),
    .rdata_o (dmem_rdata)
  );
endmodule

`default_nettype wire

// File: tb/tb_mips_processor.sv
`default_nettype none
// ============================================================================
// tb_mips_processor: directed and random programs checked every cycle against
// an instruction-level interpreter of the ISA.                     Rev 1.0
// ============================================================================
module tb_mips_processor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_processor #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset)
  );

  logic [31:0] m_rom [64];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc, m_hi, m_lo;
  logic [31:0] prog [$];
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cmp_bad;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Architectural interpreter: executes one instruction per call.
  task automatic model_step(input logic r);
    logic [31:0] ins, a, b, sx, pc4, addr;
    logic [63:0] p;
    if (r) begin
      m_pc = 0; m_hi = 0; m_lo = 0;
      return;
    end
    ins  = (m_pc < 32'd256) ? m_rom[m_pc[7:2]] : 32'h0;
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    sx   = {{16{ins[15]}}, ins[15:0]};
    pc4  = m_pc + 32'd4;
    addr = a + sx;
    m_pc = pc4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h21: m_wr(ins[15:11], a + b);
        6'h22, 6'h23: m_wr(ins[15:11], a - b);
        6'h24: m_wr(ins[15:11], a & b);
        6'h25: m_wr(ins[15:11], a | b);
        6'h2a: m_wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h2b: m_wr(ins[15:11], (a < b) ? 32'd1 : 32'd0);
        6'h08: m_pc = a;
        6'h19: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
        6'h10: m_wr(ins[15:11], m_hi);
        6'h12: m_wr(ins[15:11], m_lo);
        default: ;
      endcase
      6'h08: m_wr(ins[20:16], a + sx);
      6'h0d: m_wr(ins[20:16], a | {16'h0, ins[15:0]});
      6'h0f: m_wr(ins[20:16], {ins[15:0], 16'h0});
      6'h23: m_wr(ins[20:16], (addr < 32'd256) ? m_mem[addr[7:2]] : 32'h0);
      6'h2b: if (addr < 32'd256) m_mem[addr[7:2]] = b;
      6'h04: if (a == b) m_pc = pc4 + (sx << 2);
      6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin m_pc = {pc4[31:28], ins[25:0], 2'b00}; m_wr(5'd31, pc4); end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_bad = -1;
      for (int i = 1; i < 32; i++)
        if (cmp_bad < 0 && dut.mips.dp.gpr.registers[i] !== m_reg[i]) cmp_bad = i;
      n_checks++;
      if (cmp_bad >= 0) begin
        n_fail++;
        $display("FAIL gpr[%0d] @%0t: got %h expected %h", cmp_bad, $time,
                 dut.mips.dp.gpr.registers[cmp_bad], m_reg[cmp_bad]);
      end
      n_checks++;
      if (dut.mips.dp.pc_q !== m_pc) begin
        n_fail++;
        $display("FAIL pc @%0t: got %h expected %h", $time, dut.mips.dp.pc_q, m_pc);
      end
      cmp_bad = -1;
      for (int i = 0; i < 64; i++)
        if (cmp_bad < 0 && dut.dmem.RAM[i] !== m_mem[i]) cmp_bad = i;
      n_checks++;
      if (cmp_bad >= 0) begin
        n_fail++;
        $display("FAIL dmem[%0d] @%0t: got %h expected %h", cmp_bad, $time,
                 dut.dmem.RAM[cmp_bad], m_mem[cmp_bad]);
      end
    end
  end

  // Load prog into ROM, preload GPRs/RAM, then apply one reset edge.
  task automatic start(input bit rnd);
    logic [31:0] v;
    @(negedge clk);
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      v = (i < prog.size()) ? prog[i] : 32'h0;
      dut.imem.INSTRROM[i] = v;
      m_rom[i] = v;
    end
    for (int i = 0; i < 32; i++) begin
      v = rnd ? $urandom : 32'hcafebabe;
      dut.mips.dp.gpr.registers[i] = v;
      m_reg[i] = (i == 0) ? 32'h0 : v;
    end
    for (int i = 0; i < 64; i++) begin
      v = rnd ? $urandom : 32'h0;
      dut.dmem.RAM[i] = v;
      m_mem[i] = v;
    end
    @(posedge clk);
    model_step(1'b1);
    chk_en = 1'b1;
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    @(posedge clk);
    model_step(r);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd;
    int fns [8] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h2a, 'h2b};
    k  = $urandom_range(0, 19);
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    rd = $urandom_range(0, 7);
    case (k)
      0, 1, 2, 3, 4, 5, 6, 7: return enc_r(rs, rt, rd, fns[k]);
      8:  return enc_i('h08, rs, rt, $urandom_range(0, 65535));
      9:  return enc_i('h0d, rs, rt, $urandom_range(0, 65535));
      10: return enc_i('h0f, 0, rt, $urandom_range(0, 65535));
      11: return enc_i('h23, 0, rt, $urandom_range(0, 255));
      12: return enc_i('h2b, 0, rt, $urandom_range(0, 255));
      13: return enc_i('h04, rs, rt, $urandom_range(0, 6) - 3);
      14: return enc_j('h02, $urandom_range(0, 47));
      15: return enc_r(rs, rt, 0, 'h19);
      16: return enc_r(0, 0, rd, ($urandom_range(0, 1) != 0) ? 'h10 : 'h12);
      17: return enc_j('h03, $urandom_range(0, 47));
      18: return 32'hfc000000 | 32'($urandom_range(0, 65535));
      default: return enc_r(31, 0, 0, 'h08);
    endcase
  endfunction

  initial begin
    // Constants
    prog = '{32'h3c011234, 32'h34215678, 32'h2002ffff};
    start(1'b0);
    run(4);
    check("const $1", dut.mips.dp.gpr.registers[1], 32'h12345678);
    check("const $2", dut.mips.dp.gpr.registers[2], 32'hffffffff);
    check("const $3", dut.mips.dp.gpr.registers[3], 32'hcafebabe);

    // Fibonacci, 5 iterations
    prog = '{enc_i('h08, 0, 1, 0), enc_i('h08, 0, 2, 1), enc_i('h08, 0, 3, 5),
             enc_i('h04, 3, 0, 5), enc_r(1, 2, 4, 'h20), enc_r(2, 0, 1, 'h20),
             enc_r(4, 0, 2, 'h20), enc_i('h08, 3, 3, -1), enc_j('h02, 3)};
    start(1'b0);
    run(40);
    check("fib $1", dut.mips.dp.gpr.registers[1], 32'd5);
    check("fib $2", dut.mips.dp.gpr.registers[2], 32'd8);
    check("fib $3", dut.mips.dp.gpr.registers[3], 32'd0);

    // Reset pulse mid-loop: restart from 0 with GPRs intact
    start(1'b0);
    for (int i = 0; i < 15; i++) step(1'b0);
    step(1'b1);
    @(negedge clk);
    #1;
    check("rst pc", dut.mips.dp.pc_q, 32'h0);
    run(40);
    check("rst fib $2", dut.mips.dp.gpr.registers[2], 32'd8);

    // Call / return
    prog = '{32'h0c000003, enc_i('h08, 0, 6, 1), enc_j('h02, 2),
             enc_i('h08, 0, 2, 7), enc_r(31, 0, 0, 'h08)};
    start(1'b0);
    run(8);
    check("call $31", dut.mips.dp.gpr.registers[31], 32'h00000004);
    check("call $2", dut.mips.dp.gpr.registers[2], 32'd7);
    check("call $6", dut.mips.dp.gpr.registers[6], 32'd1);

    // Multiply
    prog = '{enc_i('h08, 0, 4, 'h7fff), enc_i('h08, 0, 5, -1), enc_r(4, 5, 0, 'h19),
             enc_r(0, 0, 2, 'h12), enc_r(0, 0, 3, 'h10)};
    start(1'b0);
    run(6);
    check("multu lo", dut.mips.dp.gpr.registers[2], 32'hffff8001);
    check("multu hi", dut.mips.dp.gpr.registers[3], 32'h00007ffe);

    // Memory, $0, unknown opcode/funct, ignored address LSBs
    prog = '{enc_i('h0f, 0, 1, 'hdead), enc_i('h0d, 1, 1, 'hbeef), enc_i('h2b, 0, 1, 8),
             enc_i('h23, 0, 6, 8), enc_i('h08, 0, 0, 5), enc_r(0, 0, 7, 'h20),
             32'hfc220001, enc_r(1, 2, 3, 'h3f), enc_i('h23, 0, 8, 10)};
    start(1'b0);
    run(10);
    check("lw $6", dut.mips.dp.gpr.registers[6], 32'hdeadbeef);
    check("$0 read", dut.mips.dp.gpr.registers[7], 32'h0);
    check("nop funct $3", dut.mips.dp.gpr.registers[3], 32'hcafebabe);
    check("lw lsb $8", dut.mips.dp.gpr.registers[8], 32'hdeadbeef);
    check("ram[2]", dut.dmem.RAM[2], 32'hdeadbeef);

    // Random programs with occasional reset pulses
    for (int s = 0; s < 6; s++) begin
      prog.delete();
      for (int i = 0; i < 48; i++) prog.push_back(rand_instr());
      start(1'b1);
      for (int c = 0; c < 200; c++) step($urandom_range(0, 39) == 0);
      @(negedge clk);
      #1;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
